// File: rtl/pattern_gen_multi.sv
// Multi-channel probe stimulus: up/down/walking-one/LFSR base pattern with rate prescaler and rotated channel copies.
// Optional PATTERN_GEN_STEP_EN adds a `step` input that forces a single advance.
module pattern_gen_multi #(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       CHANNELS   = 4,
  parameter int unsigned       PRESCALE_W = 16,
  parameter logic [WIDTH-1:0]  LFSR_TAPS  = 8'hB8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic                      load,
`ifdef PATTERN_GEN_STEP_EN
  input  logic                      step,
`endif
  input  logic [WIDTH-1:0]          seed,
  output logic [CHANNELS*WIDTH-1:0] pattern,
  output logic                      tick,
  output logic                      wrap
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_WALK = 2'd2,
    MODE_LFSR = 2'd3
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t                 mode_sel;
  logic [WIDTH-1:0]      base;
  logic [WIDTH-1:0]      ref_val;
  logic [WIDTH-1:0]      next_base;
  logic                  next_wrap;
  logic [PRESCALE_W-1:0] count;
  logic [2*WIDTH-1:0]    dbl;

  assign mode_sel = mode_t'(mode);

  always_comb begin
    next_base = base;
    next_wrap = 1'b0;
    case (mode_sel)
      MODE_UP: begin
        next_base = base + ONE;
        next_wrap = (base == '1);
      end
      MODE_DOWN: begin
        next_base = base - ONE;
        next_wrap = (base == '0);
      end
      MODE_WALK: begin
        if (base == '0) begin
          next_base = ONE;
        end else begin
          next_base = {base[WIDTH-2:0], base[WIDTH-1]};
          next_wrap = base[WIDTH-1];
        end
      end
      MODE_LFSR: begin
        if (base == '0) next_base = ONE;
        else            next_base = (base >> 1) ^ (base[0] ? LFSR_TAPS : '0);
        next_wrap = (next_base == ref_val);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      ref_val <= ONE;
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (load) begin
      base    <= seed;
      ref_val <= seed;
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
`ifdef PATTERN_GEN_STEP_EN
    end else if (step) begin
      base  <= next_base;
      count <= '0;
      tick  <= 1'b1;
      wrap  <= next_wrap;
`endif
    end else if (enable) begin
      if (count == prescale) begin
        count <= '0;
        base  <= next_base;
        tick  <= 1'b1;
        wrap  <= next_wrap;
      end else begin
        count <= count + PRESCALE_W'(1);
        tick  <= 1'b0;
        wrap  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // Channel k is base rotated left by k: a WIDTH window into {base,base}.
  always_comb begin
    dbl     = {base, base};
    pattern = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      pattern[k*WIDTH +: WIDTH] = dbl[(WIDTH-k) +: WIDTH];
    end
  end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Directed, table-driven bench for pattern_gen_multi (default 8-bit, 4-channel configuration).
module tb_pattern_gen_multi;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    mode;
  logic [PW-1:0] prescale;
  logic          load;
  logic [W-1:0]  seed;
  logic [CH*W-1:0] pattern;
  logic          tick;
  logic          wrap;
`ifdef PATTERN_GEN_STEP_EN
  logic          step = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          ld;
    logic [W-1:0]  sd;
    logic [1:0]    md;
    logic          en;
    logic [PW-1:0] ps;
    logic [W-1:0]  eb;
    logic          et;
    logic          ew;
  } vec_t;

  vec_t vecs[$];

  pattern_gen_multi #(
    .WIDTH     (W),
    .CHANNELS  (CH),
    .PRESCALE_W(PW),
    .LFSR_TAPS (8'hB8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .mode    (mode),
    .prescale(prescale),
    .load    (load),
`ifdef PATTERN_GEN_STEP_EN
    .step    (step),
`endif
    .seed    (seed),
    .pattern (pattern),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*W-1:0] exp_pat(input logic [W-1:0] b);
    logic [CH*W-1:0] r;
    logic [W-1:0]    c;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      c = (b << k) | (b >> (W - k));
      r[k*W +: W] = c;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic [W-1:0] sd, input logic [1:0] md,
                     input logic en, input logic [PW-1:0] ps,
                     input logic [W-1:0] eb, input logic et, input logic ew);
    vec_t v;
    v.ld = ld; v.sd = sd; v.md = md; v.en = en; v.ps = ps;
    v.eb = eb; v.et = et; v.ew = ew;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] sd, input logic [1:0] md,
                       input logic en, input logic [PW-1:0] ps);
    load = ld; seed = sd; mode = md; enable = en; prescale = ps;
  endtask

  initial begin
    int n;
    int first_wrap;
    int dups;
    int zeros;
    int distinct;
    logic [W-1:0] wrap_val;
    logic seen [256];

    rst_n = 1'b1;
    drive(1'b0, 8'h00, 2'd0, 1'b0, 16'd0);
    #1 rst_n = 1'b0;
    #2;
    check("reset_pattern", 64'(pattern), 64'h0);
    check("reset_tick", 64'(tick), 64'h0);
    check("reset_wrap", 64'(wrap), 64'h0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("reset_hold_pattern", 64'(pattern), 64'h0);
    enable = 1'b0;
    #2 rst_n = 1'b1;

    // up count
    add(0, 8'h00, 0, 1, 0, 8'h01, 1, 0);
    add(0, 8'h00, 0, 1, 0, 8'h02, 1, 0);
    add(0, 8'h00, 0, 1, 0, 8'h03, 1, 0);
    add(1, 8'hFE, 0, 1, 0, 8'hFE, 0, 0);
    add(0, 8'h00, 0, 1, 0, 8'hFF, 1, 0);
    add(0, 8'h00, 0, 1, 0, 8'h00, 1, 1);
    // down count
    add(1, 8'h01, 1, 1, 0, 8'h01, 0, 0);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
    add(0, 8'h00, 1, 1, 0, 8'hFF, 1, 1);
    // walking one
    add(1, 8'h00, 2, 1, 0, 8'h00, 0, 0);
    add(0, 8'h00, 2, 1, 0, 8'h01, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h02, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h04, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h08, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h10, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h20, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h40, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h80, 1, 0);
    add(0, 8'h00, 2, 1, 0, 8'h01, 1, 1);
    add(0, 8'h00, 2, 1, 0, 8'h02, 1, 0);
    add(0, 8'h00, 2, 0, 0, 8'h02, 0, 0);
    // LFSR from zero seed, then mode change mid-run
    add(1, 8'h00, 3, 1, 0, 8'h00, 0, 0);
    add(0, 8'h00, 3, 1, 0, 8'h01, 1, 0);
    add(0, 8'h00, 3, 1, 0, 8'hB8, 1, 0);
    add(0, 8'h00, 3, 1, 0, 8'h5C, 1, 0);
    add(0, 8'h00, 3, 1, 0, 8'h2E, 1, 0);
    add(0, 8'h00, 3, 1, 0, 8'h17, 1, 0);
    add(0, 8'h00, 3, 1, 0, 8'hB3, 1, 0);
    add(0, 8'h00, 0, 1, 0, 8'hB4, 1, 0);
    // prescale=3
    add(1, 8'h00, 0, 1, 3, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h01, 1, 0);
    add(0, 8'h00, 0, 1, 3, 8'h01, 0, 0);
    add(0, 8'h00, 0, 0, 3, 8'h01, 0, 0);
    add(0, 8'h00, 0, 0, 3, 8'h01, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h01, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h01, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h02, 1, 0);
    add(0, 8'h00, 0, 1, 3, 8'h02, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h02, 0, 0);
    add(1, 8'h10, 0, 1, 3, 8'h10, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h10, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h10, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h10, 0, 0);
    add(0, 8'h00, 0, 1, 3, 8'h11, 1, 0);
    add(1, 8'h33, 0, 0, 3, 8'h33, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].sd, vecs[i].md, vecs[i].en, vecs[i].ps);
      @(posedge clk); #1;
      check($sformatf("vec%0d_pattern", i), 64'(pattern), 64'(exp_pat(vecs[i].eb)));
      check($sformatf("vec%0d_tick", i), 64'(tick), 64'(vecs[i].et));
      check($sformatf("vec%0d_wrap", i), 64'(wrap), 64'(vecs[i].ew));
    end

    // LFSR full period from seed 0x01
    drive(1'b1, 8'h01, 2'd3, 1'b1, 16'd0);
    @(posedge clk); #1;
    load = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    n = 0; first_wrap = 0; dups = 0; zeros = 0; distinct = 0; wrap_val = '0;
    for (int c = 0; c < 300 && first_wrap == 0; c++) begin
      @(posedge clk); #1;
      if (tick) begin
        n++;
        if (wrap) begin
          first_wrap = n;
          wrap_val   = pattern[W-1:0];
        end else begin
          if (pattern[W-1:0] == '0) zeros++;
          if (seen[pattern[W-1:0]]) dups++;
          else distinct++;
          seen[pattern[W-1:0]] = 1'b1;
        end
      end
    end
    check("lfsr_first_wrap_tick", 64'(first_wrap), 64'd255);
    check("lfsr_wrap_value", 64'(wrap_val), 64'h01);
    check("lfsr_dups", 64'(dups), 64'd0);
    check("lfsr_zeros", 64'(zeros), 64'd0);
    check("lfsr_distinct", 64'(distinct), 64'd254);
    check("lfsr_seed_unseen", 64'(seen[1]), 64'd0);

    // async reset mid-interval, then restart spacing
    drive(1'b1, 8'h55, 2'd0, 1'b1, 16'd5);
    @(posedge clk); #1;
    load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_pattern", 64'(pattern), 64'(exp_pat(8'h55)));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pattern", 64'(pattern), 64'h0);
    check("async_reset_tick", 64'(tick), 64'h0);
    check("async_reset_wrap", 64'(wrap), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 1; c <= 20 && n == 0; c++) begin
      @(posedge clk); #1;
      if (tick) n = c;
    end
    check("post_reset_tick_cycle", 64'(n), 64'd6);
    check("post_reset_pattern", 64'(pattern), 64'(exp_pat(8'h01)));

`ifdef PATTERN_GEN_STEP_EN
    drive(1'b1, 8'h40, 2'd0, 1'b0, 16'd5);
    @(posedge clk); #1;
    load = 1'b0;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("step_pattern", 64'(pattern), 64'(exp_pat(8'h41)));
    check("step_tick", 64'(tick), 64'h1);
    @(posedge clk); #1;
    check("step_hold_pattern", 64'(pattern), 64'(exp_pat(8'h41)));
    check("step_hold_tick", 64'(tick), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_gen_multi.md
Name: pattern_gen_multi

Overview:
- Parametrised multi-channel stimulus source driving debug-core probe inputs on small FPGA boards.
- Successor to the free-running 8-bit counter used as a probe stimulus.
- Adds a selectable mode (up, down, walking-one, LFSR), a programmable rate prescaler, synchronous seed load, per-channel rotated copies, and tick/wrap strobes that can serve as trigger sources.

Parameters:
- WIDTH, 8, bits per channel and width of the base pattern register (≥2).
- CHANNELS, 4, number of output channels (1..WIDTH).
- PRESCALE_W, 16, width of the prescaler counter and the prescale input.
- LFSR_TAPS, 8'hB8, Galois feedback mask, WIDTH bits; bit i set means XOR into bit i.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  allows the prescaler to count and the pattern to advance.
- mode  in  2  0=up count, 1=down count, 2=walking-one, 3=Galois LFSR.
- prescale  in  PRESCALE_W  the pattern advances once every prescale+1 enabled cycles.
- load  in  1  synchronous load of seed into base.
- seed  in  WIDTH  load value.
- pattern  out  CHANNELS*WIDTH  channel k in bits [k*WIDTH +: WIDTH] = base rotated left by k.
- tick  out  1  one-cycle strobe, high in the cycle the new base value first appears.
- wrap  out  1  one-cycle strobe marking a pattern period boundary; only ever high together with tick.

Behaviour:
- Reset (rst_n low, any time, no clock needed): base=0, prescaler count=0, period reference ref=1, tick=0, wrap=0, so pattern=0. All state is held while rst_n is low.
- Priority at each edge: load > advance > hold.
- load=1:
  - base<=seed, ref<=seed, prescaler<=0.
  - tick<=0, wrap<=0.
  - Load is independent of enable.
- Prescaler, when enable=1 and load=0:
  - If count==prescale: count<=0 and advance.
  - Else: count<=count+1.
  - prescale=0 advances every enabled cycle.
  - If prescale is lowered below the current count, the count runs up to the maximum value, wraps to 0, then matches normally. No special handling.
- enable=0: count and base hold, tick<=0, wrap<=0.
- Advance (tick<=1 on the same edge, so tick is registered and coincides with the new pattern):
  - mode 0: base<=base+1, modulo 2^WIDTH. wrap<=1 when base was all-ones.
  - mode 1: base<=base-1. wrap<=1 when base was 0.
  - mode 2: base<=rotl(base,1). If base==0, base<=1 with no wrap. wrap<=1 when the MSB rotates into bit 0.
  - mode 3: if base==0 (lockup), base<=1. Otherwise base<=(base>>1) XOR (LFSR_TAPS if base[0] else 0). wrap<=1 when the next value equals ref.
- Mode change mid-run: takes effect on the next advance, using the current base. No reset of base or prescaler.
- pattern: combinational rotation of registered base; zero added latency relative to base.
- tick and wrap return to 0 on the cycle after any advance unless another advance occurs (possible only with prescale=0).

Optional Feature:
- Macro PATTERN_GEN_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - step=1 with load=0 forces one advance at that edge regardless of enable and prescaler count.
  - The prescaler count is cleared to 0.
  - tick and wrap behave as for a normal advance.
  - load still has priority over step.
- When undefined: no step port; advance comes only from the prescaler.

Test Plan:
- Reset then count: rst_n=0 → pattern=0, tick=0. Release with mode=0, prescale=0, enable=1 → base 0x01, 0x02, 0x03 on successive cycles, tick=1 each cycle; channel 1 = 0x02, 0x04, 0x06.
- Up/down wrap: load seed=0xFE, mode=0 → base 0xFF then 0x00 with wrap=1 only on the 0x00 cycle. mode=1, seed=0x01 → 0x00, then 0xFF with wrap=1.
- Prescale: prescale=3, mode=0 → tick every 4th cycle. Dropping enable for 2 cycles delays the next tick by exactly 2 cycles. load mid-interval restarts the 4-cycle spacing.
- Walking-one: seed=0x00, mode=2 → 0x01, 0x02, …, 0x80, 0x01. wrap=1 only on the 0x80→0x01 transition. Channel 3 shows base rotated by 3.
- LFSR: seed=0x01, mode=3, taps 0xB8 → 255 distinct nonzero values; wrap first asserts on tick 255, when the value returns to 0x01. seed=0x00 → first advance yields 0x01.
- Async reset mid-run: assert rst_n=0 between clock edges while prescale=5, count=3 → pattern, tick and wrap go to 0 immediately. After release the first tick arrives after 6 enabled cycles. With PATTERN_GEN_STEP_EN, step=1 while enable=0 advances base by exactly one.
